// File: rtl/ex_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : ex_wb_stage
//  Purpose  : Execute/writeback boundary. Registers a four-lane result bundle
//             (a0, a1, m, ls), removes same-tag duplicates (latest lane wins)
//             and drains live results over two register-file write ports,
//             stalling upstream while more than two results remain.
//  Revision : 1.0  initial release
// ============================================================================
module ex_wb_stage #(
    parameter int DW = 16,
    parameter int TW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [TW-1:0] a0_Rd_tag,
    input  logic [TW-1:0] a1_Rd_tag,
    input  logic [TW-1:0] m_Rd_tag,
    input  logic [TW-1:0] ls_Rd_tag,
    input  logic [DW-1:0] a0_res,
    input  logic [DW-1:0] a1_res,
    input  logic [DW-1:0] m_res,
    input  logic [DW-1:0] ls_res,
    input  logic          stall_in,
    output logic          wr0_en,
    output logic          wr1_en,
    output logic [TW-1:0] wr0_tag,
    output logic [TW-1:0] wr1_tag,
    output logic [DW-1:0] wr0_data,
    output logic [DW-1:0] wr1_data,
    output logic          stall_out,
    output logic [3:0]    pend_mask
);

    // Lane order is program order: index 0 = a0 (oldest) .. 3 = ls (latest).
    logic [TW-1:0] w_in_tag  [4];
    logic [DW-1:0] w_in_data [4];

    assign w_in_tag[0]  = a0_Rd_tag;
    assign w_in_tag[1]  = a1_Rd_tag;
    assign w_in_tag[2]  = m_Rd_tag;
    assign w_in_tag[3]  = ls_Rd_tag;
    assign w_in_data[0] = a0_res;
    assign w_in_data[1] = a1_res;
    assign w_in_data[2] = m_res;
    assign w_in_data[3] = ls_res;

    logic [TW-1:0] tag_q  [4];
    logic [TW-1:0] tag_d  [4];
    logic [DW-1:0] data_q [4];
    logic [DW-1:0] data_d [4];
    logic [3:0]    pend_q;
    logic [3:0]    pend_d;

    logic [2:0]    w_pend_cnt;
    logic          w_capture;
    logic [3:0]    w_new_pend;
    logic          w_sel0_vld;
    logic          w_sel1_vld;
    logic [1:0]    w_sel0;
    logic [1:0]    w_sel1;
    logic [3:0]    w_served;

    // Busy when more results are pending than the two write ports can retire.
    always_comb begin
        w_pend_cnt = {2'b00, pend_q[0]} + {2'b00, pend_q[1]}
                   + {2'b00, pend_q[2]} + {2'b00, pend_q[3]};
    end

    assign stall_out = (w_pend_cnt > 3'd2);
    assign pend_mask = pend_q;
    assign w_capture = !stall_in && !stall_out;

    // A live lane is dropped when a later lane targets the same register.
    always_comb begin
        w_new_pend = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            w_new_pend[i] = (w_in_tag[i] != '0);
            for (int j = i + 1; j < 4; j++) begin
                if (w_in_tag[i] == w_in_tag[j]) begin
                    w_new_pend[i] = 1'b0;
                end
            end
        end
    end

    // Port 0 takes the lowest pending lane, port 1 the next one.
    always_comb begin
        w_sel0_vld = 1'b0;
        w_sel1_vld = 1'b0;
        w_sel0     = 2'd0;
        w_sel1     = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (pend_q[i]) begin
                if (!w_sel0_vld) begin
                    w_sel0_vld = 1'b1;
                    w_sel0     = 2'(i);
                end else if (!w_sel1_vld) begin
                    w_sel1_vld = 1'b1;
                    w_sel1     = 2'(i);
                end
            end
        end
        w_served = ({3'b000, w_sel0_vld} << w_sel0) | ({3'b000, w_sel1_vld} << w_sel1);
    end

    assign wr0_en   = w_sel0_vld;
    assign wr1_en   = w_sel1_vld;
    assign wr0_tag  = w_sel0_vld ? tag_q[w_sel0]  : '0;
    assign wr1_tag  = w_sel1_vld ? tag_q[w_sel1]  : '0;
    assign wr0_data = w_sel0_vld ? data_q[w_sel0] : '0;
    assign wr1_data = w_sel1_vld ? data_q[w_sel1] : '0;

    // Next state: a capture replaces the bundle (old lanes all retire this
    // cycle since capture implies at most two were pending); otherwise retire
    // the lanes written this cycle.
    always_comb begin
        pend_d = pend_q & ~w_served;
        for (int i = 0; i < 4; i++) begin
            tag_d[i]  = tag_q[i];
            data_d[i] = data_q[i];
        end
        if (w_capture) begin
            pend_d = w_new_pend;
            for (int i = 0; i < 4; i++) begin
                tag_d[i]  = w_in_tag[i];
                data_d[i] = w_in_data[i];
            end
        end
    end

    // Holding registers and pending mask, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            pend_q <= pend_d;
            for (int i = 0; i < 4; i++) begin
                tag_q[i]  <= tag_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_wb_stage
//  Purpose  : Scoreboard bench for ex_wb_stage. Accepted bundles are turned
//             into an ordered list of surviving register writes; a negedge
//             monitor retires up to two per cycle and compares the ports.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ex_wb_stage;

    localparam int DW = 16;
    localparam int TW = 5;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          stall_in = 1'b0;
    logic [TW-1:0] bt [4];
    logic [DW-1:0] bd [4];

    logic          wr0_en, wr1_en, stall_out;
    logic [TW-1:0] wr0_tag, wr1_tag;
    logic [DW-1:0] wr0_data, wr1_data;
    logic [3:0]    pend_mask;

    ex_wb_stage #(.DW(DW), .TW(TW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a0_Rd_tag (bt[0]),
        .a1_Rd_tag (bt[1]),
        .m_Rd_tag  (bt[2]),
        .ls_Rd_tag (bt[3]),
        .a0_res    (bd[0]),
        .a1_res    (bd[1]),
        .m_res     (bd[2]),
        .ls_res    (bd[3]),
        .stall_in  (stall_in),
        .wr0_en    (wr0_en),
        .wr1_en    (wr1_en),
        .wr0_tag   (wr0_tag),
        .wr1_tag   (wr1_tag),
        .wr0_data  (wr0_data),
        .wr1_data  (wr1_data),
        .stall_out (stall_out),
        .pend_mask (pend_mask)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]    lane;
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks    = 0;
    int  errors    = 0;
    bit  mon_en    = 1'b0;
    bit  mon_stall = 1'b0;
    bit  acc       = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: the register file should end up holding the last value
    // written per tag; only those writes are issued, oldest lane first.
    task automatic push_bundle();
        int last [1<<TW];
        for (int k = 0; k < (1<<TW); k++) last[k] = -1;
        for (int i = 0; i < 4; i++) if (bt[i] != '0) last[bt[i]] = i;
        for (int i = 0; i < 4; i++) begin
            if (bt[i] != '0 && last[bt[i]] == i) begin
                wr_t e;
                e.lane = 2'(i);
                e.tag  = bt[i];
                e.data = bd[i];
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic set_b(input logic [TW-1:0] t0, input logic [DW-1:0] d0,
                         input logic [TW-1:0] t1, input logic [DW-1:0] d1,
                         input logic [TW-1:0] t2, input logic [DW-1:0] d2,
                         input logic [TW-1:0] t3, input logic [DW-1:0] d3);
        bt[0] = t0; bd[0] = d0;
        bt[1] = t1; bd[1] = d1;
        bt[2] = t2; bd[2] = d2;
        bt[3] = t3; bd[3] = d3;
    endtask

    // One clock edge: the model decides whether the bundle is taken.
    task automatic cycle_go();
        @(posedge clk);
        acc = !stall_in && !mon_stall && rst_n;
        if (acc && mon_en) push_bundle();
        #1;
    endtask

    // Present the current bundle until accepted (bounded).
    task automatic send(input bit rnd_stall);
        int tries = 0;
        do begin
            stall_in = rnd_stall ? ($urandom_range(0, 3) == 0) : 1'b0;
            cycle_go();
            tries++;
        end while (!acc && tries < 20);
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
        stall_in = 1'b0;
    endtask

    // Monitor: compare ports against the head of the expected write list.
    always @(negedge clk) begin
        if (mon_en) begin
            int n;
            logic [3:0] m;
            wr_t e;
            n = exp_q.size();
            m = 4'b0000;
            foreach (exp_q[k]) m[exp_q[k].lane] = 1'b1;
            chk("stall_out", {31'b0, stall_out}, {31'b0, (n > 2)});
            chk("pend_mask", {28'b0, pend_mask}, {28'b0, m});
            if (n > 0) begin
                e = exp_q.pop_front();
                chk("wr0_en", {31'b0, wr0_en}, 32'd1);
                chk("wr0_tag", {27'b0, wr0_tag}, {27'b0, e.tag});
                chk("wr0_data", {16'b0, wr0_data}, {16'b0, e.data});
            end else begin
                chk("wr0_en", {31'b0, wr0_en}, 32'd0);
                chk("wr0_tag", {27'b0, wr0_tag}, 32'd0);
                chk("wr0_data", {16'b0, wr0_data}, 32'd0);
            end
            if (n > 1) begin
                e = exp_q.pop_front();
                chk("wr1_en", {31'b0, wr1_en}, 32'd1);
                chk("wr1_tag", {27'b0, wr1_tag}, {27'b0, e.tag});
                chk("wr1_data", {16'b0, wr1_data}, {16'b0, e.data});
            end else begin
                chk("wr1_en", {31'b0, wr1_en}, 32'd0);
                chk("wr1_tag", {27'b0, wr1_tag}, 32'd0);
                chk("wr1_data", {16'b0, wr1_data}, 32'd0);
            end
            mon_stall = (n > 2);
        end else begin
            mon_stall = 1'b0;
        end
    end

    task automatic chk_idle(input string tag);
        chk({tag, "_wr0_en"}, {31'b0, wr0_en}, 32'd0);
        chk({tag, "_wr1_en"}, {31'b0, wr1_en}, 32'd0);
        chk({tag, "_stall"}, {31'b0, stall_out}, 32'd0);
        chk({tag, "_pmask"}, {28'b0, pend_mask}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with all lanes live and nonzero.
        set_b(5'd1, 16'hF00D, 5'd2, 16'hBEEF, 5'd3, 16'hCAFE, 5'd4, 16'hD00D);
        repeat (3) begin
            @(negedge clk);
            chk_idle("rst");
        end
        @(negedge clk);
        #1;
        rst_n  = 1'b1;
        chk_idle("post_rst");
        mon_en = 1'b1;
        send(1'b0);                                  // first capture: 4 lanes

        set_b(5'd3, 16'h1111, 5'd0, 16'h0, 5'd7, 16'h2222, 5'd0, 16'h0);
        send(1'b0);
        set_b(5'd12, 16'h3333, 5'd0, 16'h0, 5'd0, 16'h0, 5'd13, 16'h4444);
        send(1'b0);                                  // back-to-back

        set_b(5'd1, 16'h000A, 5'd2, 16'h000B, 5'd4, 16'h000C, 5'd9, 16'h000D);
        send(1'b0);
        set_b(5'd11, 16'h0055, 5'd0, 16'h0, 5'd0, 16'h0, 5'd0, 16'h0);
        send(1'b0);                                  // held during the stall

        set_b(5'd5, 16'h0001, 5'd5, 16'h0002, 5'd5, 16'h0003, 5'd6, 16'h0004);
        send(1'b0);                                  // duplicate tags

        // External stall for three cycles during a 4-lane drain.
        set_b(5'd1, 16'h00A1, 5'd2, 16'h00B2, 5'd4, 16'h00C3, 5'd9, 16'h00D4);
        send(1'b0);
        set_b(5'd20, 16'h7777, 5'd21, 16'h8888, 5'd0, 16'h0, 5'd0, 16'h0);
        stall_in = 1'b1;
        repeat (3) cycle_go();
        stall_in = 1'b0;
        cycle_go();
        set_b(5'd0, 16'h0, 5'd0, 16'h0, 5'd0, 16'h0, 5'd0, 16'h0);
        send(1'b0);                                  // empty bundle

        // Asynchronous reset in the middle of a drain.
        set_b(5'd1, 16'h0A0A, 5'd2, 16'h0B0B, 5'd4, 16'h0C0C, 5'd9, 16'h0D0D);
        send(1'b0);
        @(negedge clk);
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk_idle("mid_rst");
        exp_q.delete();
        set_b(5'd0, 16'h0, 5'd0, 16'h0, 5'd0, 16'h0, 5'd0, 16'h0);
        @(negedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (2) send(1'b0);

        // Randomized bundles with random external stalls.
        for (int b = 0; b < 300; b++) begin
            for (int l = 0; l < 4; l++) begin
                if ($urandom_range(0, 3) == 0) bt[l] = '0;
                else if ($urandom_range(0, 1) == 0) bt[l] = TW'($urandom_range(1, 4));
                else bt[l] = TW'($urandom_range(1, (1<<TW) - 1));
                bd[l] = DW'($urandom);
            end
            send(1'b1);
        end

        set_b(5'd0, 16'h0, 5'd0, 16'h0, 5'd0, 16'h0, 5'd0, 16'h0);
        repeat (3) send(1'b0);
        @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
